// File: rtl/shift_req_sequencer_if.sv
// Bundle of the request, shifter and result buses around shift_req_sequencer.
// Every valid/ready pair transfers on a rising clk edge where both valid and
// ready are high. The offering side holds valid and its payload steady until
// that edge. The ready side may raise or drop ready freely.
interface shift_req_sequencer_if;
  // request side
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amount;
  logic [1:0]  in_mode;
  logic [3:0]  in_tag;
  // multi-cycle shifter side
  logic        sh_start;
  logic [31:0] sh_data;
  logic [4:0]  sh_amount;
  logic [1:0]  sh_mode;
  logic [31:0] sh_result;
  logic        sh_done;
  // result side
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic        out_err;

  // sequencer view
  modport slave (
    input  in_valid, in_data, in_amount, in_mode, in_tag,
    input  sh_result, sh_done, out_ready,
    output in_ready, sh_start, sh_data, sh_amount, sh_mode,
    output out_valid, out_data, out_tag, out_err
  );

  // environment view: requester, shifter and result consumer
  modport master (
    output in_valid, in_data, in_amount, in_mode, in_tag,
    output sh_result, sh_done, out_ready,
    input  in_ready, sh_start, sh_data, sh_amount, sh_mode,
    input  out_valid, out_data, out_tag, out_err
  );
endinterface

// File: rtl/shift_req_sequencer.sv
// Queues shift requests, feeds them one at a time to a multi-cycle shifter,
// and returns each result (or an error for illegal mode / hung shifter) in
// request order. dbg_state_o encoding: 0 IDLE, 1 ISSUE, 2 WAIT, 3 HOLD.
module shift_req_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_req_sequencer_if.slave bus,
  output logic [1:0]           dbg_state_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  amount;
    logic [1:0]  mode;
    logic [3:0]  tag;
  } req_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_prev_q;
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  req_t          mem_q [DEPTH];
  req_t          head;
  req_t          hold_q;
  logic [31:0]   out_data_q, out_data_d;
  logic [3:0]    out_tag_q, out_tag_d;
  logic          out_err_q, out_err_d;
  logic          out_load;
  logic          full, empty, push, pop, done_rise;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // in_ready depends only on full, so a pop never makes room for a same-cycle push.
  assign bus.in_ready = !rst && !full;
  assign push      = bus.in_valid && bus.in_ready;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  // Only a fresh 0->1 transition completes; a done level left over from the
  // previous operation is ignored.
  assign done_rise = bus.sh_done && !done_prev_q;

  // Request storage; contents only matter between push and pop.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= '{data:   bus.in_data,
                                   amount: bus.in_amount,
                                   mode:   bus.in_mode,
                                   tag:    bus.in_tag};
    end
  end

  // Next-state, pop and result-capture decisions.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pop        = 1'b0;
    out_load   = 1'b0;
    out_data_d = '0;
    out_err_d  = 1'b0;
    out_tag_d  = hold_q.tag;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head.mode == 2'b11) begin
            // illegal mode: report without touching the shifter
            state_d   = HOLD;
            out_load  = 1'b1;
            out_err_d = 1'b1;
            out_tag_d = head.tag;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (done_rise) begin
          state_d    = HOLD;
          out_load   = 1'b1;
          out_data_d = bus.sh_result;
        end else if (cnt_q == CNT_LAST) begin
          // shifter declared hung after TIMEOUT cycles in WAIT
          state_d   = HOLD;
          out_load  = 1'b1;
          out_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointers, holding register and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      done_prev_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      hold_q      <= '0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_prev_q <= bus.sh_done;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        hold_q   <= head;
      end
      if (out_load) begin
        out_data_q <= out_data_d;
        out_tag_q  <= out_tag_d;
        out_err_q  <= out_err_d;
      end
    end
  end

  // Operand fields come straight from the holding register, so they stay
  // steady from ISSUE through WAIT.
  assign bus.sh_start  = (state_q == ISSUE);
  assign bus.sh_data   = hold_q.data;
  assign bus.sh_amount = hold_q.amount;
  assign bus.sh_mode   = hold_q.mode;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = out_data_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_err   = out_err_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_shift_req_sequencer.sv
// Bench for shift_req_sequencer: bit-serial shifter model, request driver,
// result scoreboard against an operator-level reference of the shift rules.
module tb_shift_req_sequencer;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 40;

  logic clk, rst;
  logic [1:0] dbg_state;
  shift_req_sequencer_if bus();

  shift_req_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state_o(dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [36:0] exp_q[$];   // {tag, err, data}
  int cyc = 0;
  bit hang, rand_lat, rand_ready, sh_busy;
  int sh_lat;
  int starts = 0, overlaps = 0, valid_seen = 0;
  int last_start_cyc = 0, last_acc_cyc = 0, valid_rise_cyc = 0;

  // ---------------- clock / reset block ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: shift rules written with plain operators.
  function automatic logic [36:0] ref_result(input logic [31:0] d, input logic [4:0] a,
                                             input logic [1:0] m, input logic [3:0] t);
    logic [31:0] r;
    logic e;
    e = 1'b0;
    case (m)
      2'b00:   r = d << a;
      2'b01:   r = d >> a;
      2'b10:   r = $unsigned($signed(d) >>> a);
      default: begin r = '0; e = 1'b1; end
    endcase
    return {t, e, r};
  endfunction

  // Shifter stand-in computes one bit position per step.
  function automatic logic [31:0] slow_shift(input logic [31:0] d, input logic [4:0] a,
                                             input logic [1:0] m);
    logic [31:0] r;
    r = d;
    for (int i = 0; i < int'(a); i++) begin
      case (m)
        2'b00:   r = {r[30:0], 1'b0};
        2'b01:   r = {1'b0, r[31:1]};
        2'b10:   r = {r[31], r[31:1]};
        default: r = 32'hDEAD_BEEF;
      endcase
    end
    return r;
  endfunction

  // ---------------- shifter model ----------------
  initial begin
    logic [31:0] cap_d;
    logic [4:0]  cap_a;
    logic [1:0]  cap_m;
    int lat;
    bus.sh_done   = 1'b0;
    bus.sh_result = '0;
    sh_busy       = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.sh_start && !hang) begin
        cap_d = bus.sh_data;
        cap_a = bus.sh_amount;
        cap_m = bus.sh_mode;
        lat   = rand_lat ? int'($urandom_range(1, 6)) : sh_lat;
        @(posedge clk);
        #1;
        bus.sh_done = 1'b0;
        sh_busy     = 1'b1;
        repeat (lat) @(posedge clk);
        #1;
        check("sh_operands_stable", 64'({bus.sh_data, bus.sh_amount, bus.sh_mode}),
              64'({cap_d, cap_a, cap_m}));
        bus.sh_result = slow_shift(cap_d, cap_a, cap_m);
        bus.sh_done   = 1'b1;
        sh_busy       = 1'b0;
      end
    end
  end

  // sh_start watcher: counts pulses and flags a start while an op is outstanding
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.sh_start) begin
        starts++;
        last_start_cyc = cyc + 1;
        if (sh_busy) overlaps++;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    bit prev_v, prev_stall;
    logic [36:0] snap, got;
    prev_v = 1'b0;
    prev_stall = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
        prev_stall = 1'b0;
      end else begin
        got = {bus.out_tag, bus.out_err, bus.out_data};
        if (bus.out_valid) valid_seen++;
        if (bus.out_valid && !prev_v) valid_rise_cyc = cyc;
        if (bus.out_valid && prev_stall) check("hold_stable", 64'(got), 64'(snap));
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) check("unexpected_result", 64'(got), 64'(0));
          else check("result", 64'(got), 64'(exp_q.pop_front()));
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        snap = got;
        prev_v = bus.out_valid;
      end
    end
  end

  // random result back-pressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] d, input logic [4:0] a, input logic [1:0] m,
                      input logic [3:0] t, input bit expect_timeout);
    int waited;
    bit done;
    waited = 0;
    done = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_amount = a;
    bus.in_mode   = m;
    bus.in_tag    = t;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(expect_timeout ? {t, 1'b1, 32'h0} : ref_result(d, a, m, t));
        last_acc_cyc = cyc;
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 200) begin
          check("in_ready_timeout", 64'(bus.in_ready), 64'(1));
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tagname);
    check({tagname, "_in_ready"},  64'(bus.in_ready), 64'(0));
    check({tagname, "_sh_start"},  64'(bus.sh_start), 64'(0));
    check({tagname, "_sh_fields"}, 64'({bus.sh_data, bus.sh_amount, bus.sh_mode}), 64'(0));
    check({tagname, "_out_valid"}, 64'(bus.out_valid), 64'(0));
    check({tagname, "_out_fields"}, 64'({bus.out_data, bus.out_tag, bus.out_err}), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_amount = '0;
    bus.in_mode = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
    hang = 1'b0; rand_lat = 1'b0; rand_ready = 1'b0; sh_lat = 5;

    // reset state
    #12;
    check_outputs_zero("reset");
    check("reset_state_idle", 64'(dbg_state), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", 64'(bus.in_ready), 64'(1));
    check("out_valid_after_reset", 64'(bus.out_valid), 64'(0));
    bus.out_ready = 1'b1;

    // LSL 1 by 4, tag 3, done 5 cycles after start: N+3 latency, one start
    s0 = starts;
    send(32'h0000_0001, 5'd4, 2'b00, 4'd3, 1'b0);
    wait_drain(100);
    check("latency_n_plus_3", 64'(valid_rise_cyc - (last_acc_cyc + 1)), 64'(5 + 3));
    check("lsl_one_start", 64'(starts - s0), 64'(1));

    // shift amount 0 still goes to the shifter
    s0 = starts;
    send(32'h8000_0001, 5'd0, 2'b10, 4'd9, 1'b0);
    wait_drain(100);
    check("amount0_started", 64'(starts - s0), 64'(1));

    // illegal mode: error result, shifter untouched
    s0 = starts;
    send(32'h1234_5678, 5'd3, 2'b11, 4'd7, 1'b0);
    wait_drain(100);
    check("illegal_no_start", 64'(starts - s0), 64'(0));

    // stale-high done never re-rises: timeout exactly TIMEOUT cycles into WAIT
    hang = 1'b1;
    send(32'hFFFF_0000, 5'd8, 2'b01, 4'd5, 1'b1);
    wait_drain(200);
    check("timeout_exact", 64'(valid_rise_cyc - last_start_cyc), 64'(TIMEOUT));

    // reset while one op waits and two are queued
    send(32'h0000_00AA, 5'd1, 2'b00, 4'd10, 1'b1);
    send(32'h0000_00BB, 5'd2, 2'b00, 4'd11, 1'b1);
    send(32'h0000_00CC, 5'd3, 2'b00, 4'd12, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete();
    hang = 1'b0;
    bus.sh_done = 1'b0;
    s0 = starts;
    valid_seen = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("no_valid_after_reset", 64'(valid_seen), 64'(0));
    check("no_start_after_reset", 64'(starts - s0), 64'(0));

    // five back-to-back with result stalled: FIFO fills, then drains in order
    sh_lat = 2;
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++)
      send($urandom(), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 2)), 4'(i), 1'b0);
    bus.in_valid = 1'b1;
    bus.in_tag   = 4'd6;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("in_ready_full", 64'(bus.in_ready), 64'(0));
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("queued_count", 64'(exp_q.size()), 64'(5));
    bus.out_ready = 1'b1;
    wait_drain(300);

    // random legal traffic with random stalls and shifter latency
    rand_lat = 1'b1;
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send($urandom(), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 2)),
           4'($urandom_range(0, 15)), 1'b0);
    end
    wait_drain(3000);
    rand_ready = 1'b0;
    bus.out_ready = 1'b1;

    check("sh_start_overlap", 64'(overlaps), 64'(0));
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/shift_req_sequencer.md
SHIFT_REQ_SEQUENCER -- requirements
Module: shift_req_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning request-FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 40, meaning max WAIT cycles before the shifter is declared hung.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  request offered.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-007 SHALL have port in_data  input  32  operand.
REQ-008 SHALL have port in_amount  input  5  shift count 0..31.
REQ-009 SHALL have port in_mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 illegal.
REQ-010 SHALL have port in_tag  input  4  requester ID, returned with result.
REQ-011 SHALL have port sh_start  output  1  one-cycle start pulse to the multi-cycle shifter.
REQ-012 SHALL have ports sh_data (32), sh_amount (5), sh_mode (2)  output  operand fields to the shifter.
REQ-013 SHALL have port sh_result  input  32  shifter data_out.
REQ-014 SHALL have port sh_done  input  1  shifter done level (stays high until next start).
REQ-015 SHALL have ports out_valid (1) output, out_ready (1) input  result handshake.
REQ-016 SHALL have ports out_data (32), out_tag (4), out_err (1)  output  result, tag, error flag.

Function
REQ-017 SHALL buffer requests in a DEPTH-entry FIFO {data, amount, mode, tag}; in_ready = !full.
REQ-018 SHALL accept a push when full and a pop occurs in the same cycle only if in_ready was high (no push-through when full).
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, HOLD.
REQ-020 IDLE: if FIFO non-empty, pop head into a holding register; mode 11 -> HOLD with out_err=1, out_data=0 (shifter not started); else -> ISSUE.
REQ-021 ISSUE: assert sh_start for exactly one cycle with sh_data/sh_amount/sh_mode from the holding register; -> WAIT next cycle.
REQ-022 sh_data/sh_amount/sh_mode SHALL remain stable from ISSUE until leaving WAIT.
REQ-023 WAIT: completion SHALL be a rising edge of sh_done (sh_done=1 and registered prior sh_done=0); stale high done from a previous op SHALL NOT complete.
REQ-024 WAIT on completion: capture sh_result into out_data, out_err=0, -> HOLD.
REQ-025 WAIT counter SHALL start at 0 on entry; if it reaches TIMEOUT without completion: out_data=0, out_err=1, -> HOLD.
REQ-026 HOLD: out_valid=1 with out_data/out_tag/out_err stable; on out_ready -> IDLE (next request popped no earlier than the following cycle).
REQ-027 Requests SHALL complete strictly in FIFO order; out_tag equals the popped in_tag.
REQ-028 Latency, legal request into empty idle block, shifter done rising N cycles after start: out_valid asserts N+3 cycles after acceptance.
REQ-029 in_amount=0 SHALL still be issued to the shifter.
REQ-030 sh_start SHALL never assert outside ISSUE; at most one outstanding shifter op.

Reset
REQ-031 On rst high, immediately: state IDLE, FIFO empty, in_ready=0 while rst high then 1, sh_start=0, sh_data/sh_amount/sh_mode=0, out_valid=0, out_data=0, out_tag=0, out_err=0, timeout counter=0, prior-done register=0.
REQ-032 Reset mid-operation SHALL discard queued and in-flight requests; no result emitted for them.

Verification
REQ-033 LSL 0x0000_0001 by 4, tag 3, shifter done 5 cycles after start -> one sh_start pulse, out_data=0x0000_0010, out_tag=3, out_err=0.
REQ-034 Five back-to-back requests, DEPTH=4, out_ready=0 -> in_ready drops after 4 accepted (plus 1 in holding reg); release out_ready -> tags returned in order.
REQ-035 in_mode=11, tag 7 -> no sh_start, out_valid with out_data=0, out_err=1, out_tag=7.
REQ-036 sh_done held high from prior op and never re-rises -> out_err=1, out_data=0 exactly TIMEOUT cycles after WAIT entry.
REQ-037 rst asserted during WAIT with 2 queued -> all outputs zero immediately; after release, no out_valid until new request.
REQ-038 Random legal traffic with random out_ready stalls vs. reference model -> every result matches shift of in_data, zero sh_start overlap.
